// File: rtl/event_window_counter.sv
// Counts rising edges of In1 over fixed windows of WIN_LEN cycles and hands each
// window's total to a consumer through a Valid/Ready register with overrun tracking.
module event_window_counter #(
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned WIN_LEN = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             En,
    input  logic             In1,
    input  logic             Ready,
    output logic [CNT_W-1:0] Count,
    output logic             Valid,
    output logic             Sat,
    output logic             Overrun,
    output logic             Busy
);

    localparam int unsigned        TMR_W    = $clog2(WIN_LEN);
    localparam logic [TMR_W-1:0]   TMR_LAST = TMR_W'(WIN_LEN - 1);
    localparam logic [CNT_W-1:0]   CNT_MAX  = '1;

    typedef enum logic {StIdle, StRun} state_e;

    state_e             state_q, state_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [CNT_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               acc_sat_q, acc_sat_d;
    logic               prev_q, prev_d;
    logic               valid_q, valid_d;
    logic               sat_q, sat_d;
    logic               overrun_q, overrun_d;
    logic               busy_q, busy_d;

    logic               evt;
    logic               acc_full;
    logic               win_close;

    always_comb begin
        evt       = In1 & ~prev_q;
        acc_full  = (acc_q == CNT_MAX);
        win_close = (state_q == StRun) && (timer_q == TMR_LAST);

        prev_d    = In1;
        state_d   = En ? StRun : StIdle;
        busy_d    = (state_d == StRun);

        // Timer and accumulator fall back to zero whenever not actively counting.
        timer_d   = '0;
        acc_d     = '0;
        acc_sat_d = 1'b0;

        count_d   = count_q;
        sat_d     = sat_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;

        if (valid_q && Ready) begin
            valid_d   = 1'b0;
            overrun_d = 1'b0;
        end

        if (win_close) begin
            count_d   = (evt && !acc_full) ? acc_q + 1'b1 : acc_q;
            sat_d     = acc_sat_q | (evt & acc_full);
            valid_d   = 1'b1;
            overrun_d = valid_q & ~Ready;
        end else if (state_q == StRun && En) begin
            timer_d   = timer_q + 1'b1;
            acc_d     = (evt && !acc_full) ? acc_q + 1'b1 : acc_q;
            acc_sat_d = acc_sat_q | (evt & acc_full);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= StIdle;
            timer_q   <= '0;
            acc_q     <= '0;
            acc_sat_q <= 1'b0;
            prev_q    <= 1'b0;
            count_q   <= '0;
            valid_q   <= 1'b0;
            sat_q     <= 1'b0;
            overrun_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            acc_q     <= acc_d;
            acc_sat_q <= acc_sat_d;
            prev_q    <= prev_d;
            count_q   <= count_d;
            valid_q   <= valid_d;
            sat_q     <= sat_d;
            overrun_q <= overrun_d;
            busy_q    <= busy_d;
        end
    end

    assign Count   = count_q;
    assign Valid   = valid_q;
    assign Sat     = sat_q;
    assign Overrun = overrun_q;
    assign Busy    = busy_q;

endmodule
